dlx_mem_ctrl: RTL and testbench
===============================

// Module: dlx_mem_ctrl
// PURPOSE
//  Data-memory controller between the DLX pipeline MEM stage and the word-wide sram model.
//  Accepts one load/store request at a time and issues word-aligned sram accesses.
//  Handles byte/halfword stores by read-modify-write, and returns sign/zero-extended loads.
//  Stalls the pipeline via req_ready until the access completes.
// PARAMETERS
//  READ_WAIT  1  cycles oe/cs held before mem_dout is sampled (legal range 1..15)
// PORTS
//  clk         in   1   pipeline clock; all state changes on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  req_valid   in   1   MEM stage has a load/store this cycle
//  req_ready   out  1   controller idle; request accepted when req_valid&&req_ready
//  req_we      in   1   1=store, 0=load
//  req_size    in   2   00=byte, 01=half, 10=word, 11=reserved (treated as word)
//  req_unsigned in  1   load zero-extends when 1, sign-extends when 0
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid  out  1   one-cycle pulse: access complete
//  resp_rdata  out  32  load result, valid with resp_valid; 0 for stores
//  resp_err    out  1   with resp_valid: misaligned request, no sram access made
//  mem_cs/mem_oe/mem_we  out  1 each  sram strobes
//  mem_addr    out  32  {addr[31:2],2'b00}
//  mem_din     out  32  sram write data
//  mem_dout    in   32  sram read data
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; req_ready=1 after release; resp_*, mem_* all 0; captured request discarded,
//    including mid-access (mem_we drops immediately, no partial write is retried).
//  - Request fields captured into registers on acceptance; outputs derive only from registers.
//  - Byte order big-endian: byte offset 0 -> bits[31:24], 3 -> [7:0]; half offset 0 -> [31:16], 2 -> [15:0].
//  - FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, DONE. req_ready=1 only in IDLE.
//    IDLE: on accept -> word store: WR; sub-word store: RMW_RD; load: RD; misaligned: DONE (err).
//    RD / RMW_RD: cs=oe=1, mem_addr stable; wait counter counts READ_WAIT cycles, then samples mem_dout.
//      RD -> DONE; RMW_RD -> RMW_WR.
//    WR / RMW_WR: exactly one cycle with cs=we=1, oe=0; mem_din = wdata (WR) or sampled word with
//      target lane replaced (RMW_WR); -> DONE.
//    DONE: all mem_* strobes 0 (guarantees we deasserted between writes); resp_valid=1 one cycle; -> IDLE.
//  - Latency accept->resp_valid: word store 2; load READ_WAIT+1; sub-word store READ_WAIT+2; error 1.
//  - Back-to-back: next request accepted the cycle after DONE (one IDLE cycle minimum).
//  - resp_rdata/resp_err hold their value until next resp_valid; reset to 0.
//  - mem_addr and mem_din held constant throughout an access; 0 in IDLE.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no sram access, DONE with
//    resp_err=1, resp_rdata=0.
//  MISALIGN_TRAP_EN undefined: resp_err tied 0; half uses addr[1] only, word ignores addr[1:0]
//    (address silently aligned); access proceeds normally.
// TESTING
//  1 reset mid-RMW: assert rst_n=0 in RMW_WR -> mem_we=0 same cycle, req_ready=1 after release, resp_valid=0.
//  2 word store 0x100<-0xDEADBEEF, then word load 0x100 -> resp_rdata=0xDEADBEEF, latency 2 and READ_WAIT+1.
//  3 sb 0x101<-0x7F over word 0x11223344 -> sram word 0x117F3344; lb 0x101 -> 0x0000007F.
//  4 sh 0x102<-0x8001, lh 0x102 -> 0xFFFF8001; lhu 0x102 -> 0x00008001.
//  5 MISALIGN_TRAP_EN: lw 0x103 -> resp_err=1 after 1 cycle, cs never asserted; without macro -> reads 0x100.
//  6 req_valid held high for 4 stores -> exactly 4 accepts, mem_we low between each write, req_ready low while busy.

Source files
------------

// File: rtl/dlx_mem_ctrl.sv
// rtl/dlx_mem_ctrl.sv - DLX MEM-stage data-memory controller with read-modify-write sub-word stores
// Optional feature macro: MISALIGN_TRAP_EN (reject misaligned half/word accesses with resp_err)
module dlx_mem_ctrl #(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [1:0]  cap_size;
  logic [1:0]  cap_off;
  logic        cap_unsigned;
  logic [31:0] cap_wdata;
  logic        req_misaligned;

`ifdef MISALIGN_TRAP_EN
  assign req_misaligned = (req_size == 2'b01 && req_addr[0]) ||
                          (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign req_misaligned = 1'b0;
`endif

  // Big-endian lanes: byte offset 0 is bits [31:24]; halves select on off[1] only.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (size)
      2'b00:   load_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] off, input logic [1:0] size);
    logic [31:0] m;
    m = w;
    if (size == 2'b00) begin
      case (off)
        2'd0:    m[31:24] = d[7:0];
        2'd1:    m[23:16] = d[7:0];
        2'd2:    m[15:8]  = d[7:0];
        default: m[7:0]   = d[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (off[1]) m[15:0] = d[15:0];
      else        m[31:16] = d[15:0];
    end else begin
      m = d;
    end
    store_merge = m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      cap_size     <= 2'b00;
      cap_off      <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_wdata    <= 32'd0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_err     <= 1'b0;
      mem_cs       <= 1'b0;
      mem_oe       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_din      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready    <= 1'b0;
            cap_size     <= req_size;
            cap_off      <= req_addr[1:0];
            cap_unsigned <= req_unsigned;
            cap_wdata    <= req_wdata;
            wait_cnt     <= 4'(READ_WAIT - 1);
            if (req_misaligned) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              mem_cs   <= 1'b1;
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_we && req_size[1]) begin
                state   <= WR;
                mem_we  <= 1'b1;
                mem_din <= req_wdata;
              end else if (req_we) begin
                state  <= RMW_RD;
                mem_oe <= 1'b1;
              end else begin
                state  <= RD;
                mem_oe <= 1'b1;
              end
            end
          end
        end
        RD: begin
          if (wait_cnt == 4'd0) begin
            mem_cs     <= 1'b0;
            mem_oe     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_extract(mem_dout, cap_off, cap_size, cap_unsigned);
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RMW_RD: begin
          if (wait_cnt == 4'd0) begin
            mem_oe  <= 1'b0;
            mem_we  <= 1'b1;
            mem_din <= store_merge(mem_dout, cap_wdata, cap_off, cap_size);
            state   <= RMW_WR;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        WR, RMW_WR: begin
          mem_cs     <= 1'b0;
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          state      <= DONE;
        end
        DONE: begin
          resp_valid <= 1'b0;
          mem_addr   <= 32'd0;
          mem_din    <= 32'd0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_mem_ctrl.sv
// tb/tb_dlx_mem_ctrl.sv - directed self-checking bench for dlx_mem_ctrl with a word-wide sram model
module tb_dlx_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_cs, mem_oe, mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;

  logic [31:0] sram [0:255];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign mem_dout = sram[mem_addr[9:2]];
  always @(posedge clk) if (mem_cs && mem_we) sram[mem_addr[9:2]] <= mem_din;

  dlx_mem_ctrl #(.READ_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // lat counts rising edges from acceptance to the first cycle showing resp_valid
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic cs_seen);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; cs_seen = mem_cs;
    while (!resp_valid && lat < 50) begin @(negedge clk); lat++; cs_seen |= mem_cs; end
    rdata = resp_rdata; err = resp_err;
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    logic err, cs_seen, found;
    int acc, writes, b2b, busy_ready;
    logic prev_we, accept_now;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_strobes", {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_rdata", resp_rdata, 32'd0);

    // reset asserted while the RMW write strobe is up
    do_req(1'b1, 2'b10, 1'b0, 32'h104, 32'h55667788, lat, rd, err, cs_seen);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h104; req_wdata = 32'hAA;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_we) found = 1'b1;
    end
    chk("rmw_we_reached", {31'd0, found}, 32'd1);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst_mid_rmw_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mid_rmw_cs", {31'd0, mem_cs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("rst_mid_resp2", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_sram", sram[8'h41], 32'h55667788);

    // word store/load
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd, err, cs_seen);
    chk("sw_lat", lat, 2);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_sram", sram[8'h40], 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, lat, rd, err, cs_seen);
    chk("lw_lat", lat, 2);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("lw_hold_rdata", resp_rdata, 32'hDEADBEEF);
    chk("lw_resp_pulse", {31'd0, resp_valid}, 32'd0);

    // byte stores/loads
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, lat, rd, err, cs_seen);
    do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000007F, lat, rd, err, cs_seen);
    chk("sb_lat", lat, 3);
    chk("sb_sram", sram[8'h40], 32'h117F3344);
    do_req(1'b0, 2'b00, 1'b0, 32'h101, 32'd0, lat, rd, err, cs_seen);
    chk("lb_101", rd, 32'h0000007F);
    do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'd0, lat, rd, err, cs_seen);
    chk("lb_100", rd, 32'h00000011);
    do_req(1'b1, 2'b00, 1'b0, 32'h103, 32'h12345680, lat, rd, err, cs_seen);
    chk("sb_103_sram", sram[8'h40], 32'h117F3380);
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, lat, rd, err, cs_seen);
    chk("lb_103_sext", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, lat, rd, err, cs_seen);
    chk("lbu_103", rd, 32'h00000080);

    // halfword stores/loads
    do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'hCAFE8001, lat, rd, err, cs_seen);
    chk("sh_sram", sram[8'h40], 32'h117F8001);
    do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, lat, rd, err, cs_seen);
    chk("lh_102", rd, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'd0, lat, rd, err, cs_seen);
    chk("lhu_102", rd, 32'h00008001);
    do_req(1'b0, 2'b01, 1'b0, 32'h100, 32'd0, lat, rd, err, cs_seen);
    chk("lh_100", rd, 32'h0000117F);

    // reserved size behaves as word
    do_req(1'b1, 2'b11, 1'b0, 32'h120, 32'h0BADF00D, lat, rd, err, cs_seen);
    chk("size11_sram", sram[8'h48], 32'h0BADF00D);

    // misaligned accesses
    do_req(1'b0, 2'b10, 1'b0, 32'h103, 32'd0, lat, rd, err, cs_seen);
`ifdef MISALIGN_TRAP_EN
    chk("lw_mis_err", {31'd0, err}, 32'd1);
    chk("lw_mis_lat", lat, 1);
    chk("lw_mis_cs", {31'd0, cs_seen}, 32'd0);
    chk("lw_mis_rdata", rd, 32'd0);
    do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'd0, lat, rd, err, cs_seen);
    chk("lh_mis_err", {31'd0, err}, 32'd1);
`else
    chk("lw_mis_err", {31'd0, err}, 32'd0);
    chk("lw_mis_lat", lat, 2);
    chk("lw_mis_rdata", rd, 32'h117F8001);
    do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'd0, lat, rd, err, cs_seen);
    chk("lh_mis_rdata", rd, 32'h0000117F);
`endif

    // req_valid held high across four word stores
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h200; req_wdata = 32'hA0000000;
    acc = 0; writes = 0; b2b = 0; busy_ready = 0; prev_we = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mem_we) begin writes++; if (prev_we) b2b++; end
      prev_we = mem_we;
      if (req_ready && (mem_cs || resp_valid)) busy_ready++;
      accept_now = req_ready && req_valid;
      @(negedge clk);
      if (accept_now) begin
        acc++;
        if (acc == 4) req_valid = 1'b0;
        else begin req_addr += 32'd4; req_wdata += 32'd1; end
      end
    end
    chk("b2b_accepts", acc, 4);
    chk("b2b_writes", writes, 4);
    chk("b2b_we_gap", b2b, 0);
    chk("b2b_ready_busy", busy_ready, 0);
    for (int i = 0; i < 4; i++) chk("b2b_sram", sram[8'h80 + i], 32'hA0000000 + 32'(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
